ycbcr2rgb: RTL and testbench
============================

YCBCR2RGB -- requirements
Module: ycbcr2rgb

Interface
REQ-001 The block SHALL expose these ports, clock and reset first (name, direction, width, meaning):
- iClk  in  1  pixel clock; all state on rising edge.
- iRst_n  in  1  reset, asynchronous assert, active-low.
- iY / iCb / iCr  in  8 each  input pixel components, unsigned.
- iHSync, iVSync, iLineValid, iFrameValid  in  1 each  input stream timing.
- iMode  in  1  1 = convert YCbCr->RGB, 0 = bypass.
- oR / oG / oB  out  8 each  output pixel.
- oHSync, oVSync, oLineValid, oFrameValid  out  1 each  delayed timing.
- oModeActive  out  1  mode applied to the frame currently at the output.
- oClampCount  out  16  clamped components counted in the last completed output frame.
REQ-002 The design SHALL use one clock, iClk; reset SHALL be asynchronous and active-low on iRst_n.

Function
REQ-003 Pixel data and all four timing signals SHALL have a fixed latency of exactly 3 iClk cycles, identical in both modes.
REQ-004 Pipeline stages:
- S1 registers inputs and forms dCb = Cb-128 and dCr = Cr-128 (signed 9-bit).
- S2 forms products and sums.
- S3 rounds, adds Y, clamps and registers the outputs.
REQ-005 Conversion SHALL be BT.601 full-range in Q8, using arithmetic shift (floor):
- R = Y + ((359*dCr + 128) >>> 8)
- G = Y + ((-88*dCb - 183*dCr + 128) >>> 8)
- B = Y + ((454*dCb + 128) >>> 8)
REQ-006 Intermediate terms SHALL be at least 19-bit signed; no intermediate overflow is permitted.
REQ-007 Each result SHALL clamp to 0..255: below 0 -> 0, above 255 -> 255.
REQ-008 In bypass, oR/oG/oB SHALL equal iY/iCb/iCr delayed 3 cycles, and no clamping is counted.
REQ-009 Mode latch:
- An input rising edge of iFrameValid (previous 0, current 1) SHALL sample iMode.
- The sampled mode SHALL apply to every pixel of that frame.
- Changes to iMode mid-frame SHALL be ignored until the next rising edge.
REQ-010 oModeActive SHALL travel with the pipeline, aligned to oFrameValid.
REQ-011 Before the first frame rising edge after reset, the mode SHALL be bypass.
REQ-012 Clamp counting:
- A 16-bit counter SHALL add the number of components clamped in each converted output pixel (0..3) while oFrameValid=1 and oLineValid=1.
- The counter SHALL saturate at 0xFFFF.
REQ-013 On an output falling edge of oFrameValid, oClampCount SHALL load the counter value and the counter SHALL clear in the same cycle; the increment from that cycle's pixel SHALL be discarded.
REQ-014 Pixels outside iLineValid&iFrameValid SHALL still be converted, but SHALL NOT be counted.

Reset
REQ-015 While iRst_n=0 the block SHALL hold:
- oR/oG/oB = 0; all output syncs and valids = 0.
- oModeActive = 0; oClampCount = 0.
- All pipeline registers, edge-detect registers and the counter = 0.
REQ-016 Reset asserted mid-frame SHALL take effect immediately (asynchronously).
REQ-017 After release, the first valid output SHALL appear 3 cycles after the first valid input; no stale data SHALL emerge.

Verification
REQ-018 Gray: mode=1, Y/Cb/Cr=128/128/128 -> RGB 128/128/128 after exactly 3 cycles; oClampCount=0 at frame end.
REQ-019 Red: mode=1, Y/Cb/Cr=76/85/255 -> RGB 254/0/0; counts 2 clamps per valid pixel.
REQ-020 Saturation: mode=1, 255/128/255 -> RGB 255/164/255; 0/255/128 -> RGB 0/0/225. Each pixel counts 1 clamp.
REQ-021 Mode latch: iMode toggled 0->1 mid-frame -> that frame stays bypass with oModeActive=0; the next frame converts with oModeActive=1 from its first output cycle.
REQ-022 Clamp saturation and reset:
- A 70000-pixel all-red frame -> oClampCount=0xFFFF.
- iRst_n pulsed low mid-frame -> all outputs 0 immediately.
- The next frame -> bypass mode with exact 3-cycle alignment of the syncs.

Source files
------------

// File: rtl/ycbcr2rgb_if.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb_if -- pixel stream bundle for the YCbCr -> RGB converter.
//
// Source side (master) drives:
//   iY, iCb, iCr        input pixel components, unsigned
//   iHSync, iVSync      input timing
//   iLineValid          input line-active qualifier
//   iFrameValid         input frame-active qualifier
//   iMode               1 = convert, 0 = bypass (sampled at frame start)
// Converter side (slave) drives:
//   oR, oG, oB          output pixel
//   oHSync, oVSync      timing delayed to match the pixel
//   oLineValid          delayed line qualifier
//   oFrameValid         delayed frame qualifier
//   oModeActive         mode of the frame currently at the output
//   oClampCount         clamped components in the last completed output frame
// ---------------------------------------------------------------------------
interface ycbcr2rgb_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] iY;
    logic [DATA_W-1:0] iCb;
    logic [DATA_W-1:0] iCr;
    logic              iHSync;
    logic              iVSync;
    logic              iLineValid;
    logic              iFrameValid;
    logic              iMode;

    logic [DATA_W-1:0] oR;
    logic [DATA_W-1:0] oG;
    logic [DATA_W-1:0] oB;
    logic              oHSync;
    logic              oVSync;
    logic              oLineValid;
    logic              oFrameValid;
    logic              oModeActive;
    logic [15:0]       oClampCount;

    modport master (
        output iY, iCb, iCr, iHSync, iVSync, iLineValid, iFrameValid, iMode,
        input  oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid,
        input  oModeActive, oClampCount
    );

    modport slave (
        input  iY, iCb, iCr, iHSync, iVSync, iLineValid, iFrameValid, iMode,
        output oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid,
        output oModeActive, oClampCount
    );
endinterface

// File: rtl/ycbcr2rgb.sv
// ---------------------------------------------------------------------------
// ycbcr2rgb -- three-stage BT.601 full-range YCbCr -> RGB converter.
//
// Ports:
//   iClk     pixel clock, all state on the rising edge
//   iRst_n   asynchronous active-low reset; clears every register
//   bus      ycbcr2rgb_if.slave: pixel/timing in, pixel/timing out,
//            oModeActive and the per-frame oClampCount
//
// Pixels and timing leave exactly three cycles after they enter, in both
// convert and bypass mode. The mode is sampled on the input rising edge of
// iFrameValid and rides down the pipeline with the pixel. Components that
// clamp are counted only for converted pixels inside line&frame valid; the
// total is published when oFrameValid falls.
// ---------------------------------------------------------------------------
module ycbcr2rgb #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 10
) (
    input  logic       iClk,
    input  logic       iRst_n,
    ycbcr2rgb_if.slave bus
);
    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = 19;
    localparam int SUM_W  = DATA_W + 3;
    localparam int CNT_W  = 16;

    localparam logic signed [COEF_W-1:0] K_R_CR = COEF_W'(359);
    localparam logic signed [COEF_W-1:0] K_G_CB = COEF_W'(88);
    localparam logic signed [COEF_W-1:0] K_G_CR = COEF_W'(183);
    localparam logic signed [COEF_W-1:0] K_B_CB = COEF_W'(454);

    localparam logic signed [DIFF_W-1:0] CHROMA_MID = DIFF_W'(128);
    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(128);
    localparam logic signed [SUM_W-1:0]  PIX_MAX    = SUM_W'(255);
    localparam logic [DATA_W-1:0]        SIGN_FLIP  = {1'b1, {(DATA_W-1){1'b0}}};

    // Sign-extend both operands to the product width before multiplying.
    function automatic logic signed [PROD_W-1:0] mulK(
        input logic signed [COEF_W-1:0] k,
        input logic signed [DIFF_W-1:0] d
    );
        return PROD_W'(k) * PROD_W'(d);
    endfunction

    // Floor-divide the rounded Q8 chroma term and add luma.
    function automatic logic signed [SUM_W-1:0] addLuma(
        input logic [DATA_W-1:0]        y,
        input logic signed [PROD_W-1:0] s
    );
        logic signed [PROD_W-1:0] q;
        q = s >>> 8;
        return $signed({{(SUM_W-DATA_W){1'b0}}, y}) + $signed(q[SUM_W-1:0]);
    endfunction

    function automatic logic isClamped(input logic signed [SUM_W-1:0] v);
        return v[SUM_W-1] || (v > PIX_MAX);
    endfunction

    function automatic logic [DATA_W-1:0] clampPix(input logic signed [SUM_W-1:0] v);
        if (v[SUM_W-1])
            return '0;
        else if (v > PIX_MAX)
            return '1;
        else
            return v[DATA_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] satAdd(
        input logic [CNT_W-1:0] acc,
        input logic [1:0]       n
    );
        logic [CNT_W:0] s;
        s = {1'b0, acc} + {{(CNT_W-1){1'b0}}, n};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Frame-start mode latch: the first pixel of a frame already uses the
    // freshly sampled iMode; later pixels use the latched copy.
    logic fvPrev;
    logic modeLatch;
    logic frameRise;
    logic modeCur;

    assign frameRise = bus.iFrameValid & ~fvPrev;
    assign modeCur   = frameRise ? bus.iMode : modeLatch;

    logic [DATA_W-1:0]        y_p1, y_p2;
    logic signed [DIFF_W-1:0] dCb_p1, dCr_p1, dCb_p2, dCr_p2;
    logic signed [PROD_W-1:0] sumR_p2, sumG_p2, sumB_p2;
    logic [3:0]               tim_p1, tim_p2, tim_p3;   // {hs, vs, lv, fv}
    logic                     mode_p1, mode_p2, mode_p3;
    logic [DATA_W-1:0]        r_p3, g_p3, b_p3;
    logic [1:0]               nClamp_p3;

    logic signed [SUM_W-1:0]  rawR, rawG, rawB;
    logic                     clR, clG, clB;

    assign rawR = addLuma(y_p2, sumR_p2);
    assign rawG = addLuma(y_p2, sumG_p2);
    assign rawB = addLuma(y_p2, sumB_p2);
    assign clR  = isClamped(rawR);
    assign clG  = isClamped(rawG);
    assign clB  = isClamped(rawB);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            fvPrev    <= 1'b0;
            modeLatch <= 1'b0;
            y_p1      <= '0;
            dCb_p1    <= '0;
            dCr_p1    <= '0;
            tim_p1    <= '0;
            mode_p1   <= 1'b0;
            y_p2      <= '0;
            dCb_p2    <= '0;
            dCr_p2    <= '0;
            sumR_p2   <= '0;
            sumG_p2   <= '0;
            sumB_p2   <= '0;
            tim_p2    <= '0;
            mode_p2   <= 1'b0;
            r_p3      <= '0;
            g_p3      <= '0;
            b_p3      <= '0;
            tim_p3    <= '0;
            mode_p3   <= 1'b0;
            nClamp_p3 <= '0;
        end else begin
            fvPrev <= bus.iFrameValid;
            if (frameRise)
                modeLatch <= bus.iMode;

            // ---- S1: register inputs, centre chroma ----
            y_p1    <= bus.iY;
            dCb_p1  <= $signed({1'b0, bus.iCb}) - CHROMA_MID;
            dCr_p1  <= $signed({1'b0, bus.iCr}) - CHROMA_MID;
            tim_p1  <= {bus.iHSync, bus.iVSync, bus.iLineValid, bus.iFrameValid};
            mode_p1 <= modeCur;

            // ---- S2: Q8 products and sums with the rounding half ----
            y_p2    <= y_p1;
            dCb_p2  <= dCb_p1;
            dCr_p2  <= dCr_p1;
            sumR_p2 <= mulK(K_R_CR, dCr_p1) + ROUND_HALF;
            sumG_p2 <= ROUND_HALF - mulK(K_G_CB, dCb_p1) - mulK(K_G_CR, dCr_p1);
            sumB_p2 <= mulK(K_B_CB, dCb_p1) + ROUND_HALF;
            tim_p2  <= tim_p1;
            mode_p2 <= mode_p1;

            // ---- S3: shift, add luma, clamp, register outputs ----
            tim_p3  <= tim_p2;
            mode_p3 <= mode_p2;
            if (mode_p2) begin
                r_p3      <= clampPix(rawR);
                g_p3      <= clampPix(rawG);
                b_p3      <= clampPix(rawB);
                nClamp_p3 <= {1'b0, clR} + {1'b0, clG} + {1'b0, clB};
            end else begin
                // Raw chroma is the centred value with its top bit flipped.
                r_p3      <= y_p2;
                g_p3      <= dCb_p2[DATA_W-1:0] ^ SIGN_FLIP;
                b_p3      <= dCr_p2[DATA_W-1:0] ^ SIGN_FLIP;
                nClamp_p3 <= '0;
            end
        end
    end

    // Clamp accounting runs on the registered output stream, so a frame's
    // total is complete exactly when oFrameValid drops.
    logic             ofvPrev;
    logic             outFrameFall;
    logic [CNT_W-1:0] clampAcc;
    logic [CNT_W-1:0] clampCount;

    assign outFrameFall = ofvPrev & ~tim_p3[0];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ofvPrev    <= 1'b0;
            clampAcc   <= '0;
            clampCount <= '0;
        end else begin
            ofvPrev <= tim_p3[0];
            if (outFrameFall) begin
                clampCount <= clampAcc;
                clampAcc   <= '0;
            end else if (tim_p3[0] && tim_p3[1]) begin
                clampAcc <= satAdd(clampAcc, nClamp_p3);
            end
        end
    end

    assign bus.oR          = r_p3;
    assign bus.oG          = g_p3;
    assign bus.oB          = b_p3;
    assign bus.oHSync      = tim_p3[3];
    assign bus.oVSync      = tim_p3[2];
    assign bus.oLineValid  = tim_p3[1];
    assign bus.oFrameValid = tim_p3[0];
    assign bus.oModeActive = mode_p3;
    assign bus.oClampCount = clampCount;
endmodule

// File: tb/tb_ycbcr2rgb.sv
// ---------------------------------------------------------------------------
// tb_ycbcr2rgb -- scoreboard bench for ycbcr2rgb.
// Each driven cycle pushes the expected output (due three cycles later) into
// a queue; an independent monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_ycbcr2rgb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ycbcr2rgb_if bus ();

    ycbcr2rgb dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int     due;
        int     r, g, b;
        bit [3:0] tim;   // {hs, vs, lv, fv}
        bit     mode;
        int     cc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    bit mPrevFv   = 1'b0;
    bit mMode     = 1'b0;
    int mAcc      = 0;
    int mCc       = 0;
    int ccNext    = 0;
    bit ccPending = 1'b0;

    function automatic int lim(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int conv(input int y, input real num);
        return y + int'($floor(num / 256.0));
    endfunction

    task automatic refPixel(input int y, cb, cr, input bit md,
                            output int r, g, b, n);
        int rr, gg, bb, dcb, dcr;
        if (!md) begin
            r = y; g = cb; b = cr; n = 0;
        end else begin
            dcb = cb - 128;
            dcr = cr - 128;
            rr = conv(y, 359.0 * dcr + 128.0);
            gg = conv(y, -88.0 * dcb - 183.0 * dcr + 128.0);
            bb = conv(y, 454.0 * dcb + 128.0);
            n = (rr != lim(rr)) + (gg != lim(gg)) + (bb != lim(bb));
            r = lim(rr); g = lim(gg); b = lim(bb);
        end
    endtask

    task automatic drivePix(input int y, cb, cr, input bit hs, vs, lv, fv, md);
        exp_t e;
        int r, g, b, n;
        @(posedge clk);
        #1;
        bus.iY = 8'(y);
        bus.iCb = 8'(cb);
        bus.iCr = 8'(cr);
        bus.iHSync = hs;
        bus.iVSync = vs;
        bus.iLineValid = lv;
        bus.iFrameValid = fv;
        bus.iMode = md;
        if (ccPending) begin
            mCc = ccNext;
            ccPending = 1'b0;
        end
        if (fv && !mPrevFv) mMode = md;
        if (!fv && mPrevFv) begin
            ccNext = mAcc;
            mAcc = 0;
            ccPending = 1'b1;
        end
        mPrevFv = fv;
        refPixel(y, cb, cr, mMode, r, g, b, n);
        if (fv && lv) mAcc = (mAcc + n > 65535) ? 65535 : mAcc + n;
        e.due = cyc + 3;
        e.r = r; e.g = g; e.b = b;
        e.tim = {hs, vs, lv, fv};
        e.mode = mMode;
        e.cc = mCc;
        q.push_back(e);
    endtask

    task automatic genPix(input int kind, input int idx, output int y, cb, cr);
        int vals[7] = '{0, 1, 127, 128, 129, 254, 255};
        case (kind)
            0: begin y = 128; cb = 128; cr = 128; end
            1: begin y = 76;  cb = 85;  cr = 255; end
            2: if (idx % 2 == 0) begin y = 255; cb = 128; cr = 255; end
               else begin y = 0; cb = 255; cr = 128; end
            4: begin y = 0; cb = 0; cr = 255; end
            5: begin
                y  = vals[$urandom_range(0, 6)];
                cb = vals[$urandom_range(0, 6)];
                cr = vals[$urandom_range(0, 6)];
            end
            default: begin
                y  = $urandom_range(0, 255);
                cb = $urandom_range(0, 255);
                cr = $urandom_range(0, 255);
            end
        endcase
    endtask

    // One frame: vsync lead-in, lines with two blanking cycles each, tail.
    // toggleAt >= 0 flips iMode after that many active pixels.
    task automatic sendFrame(input int kind, input bit md, input int lines,
                             input int pix, input int toggleAt);
        int y, cb, cr, idx;
        bit m;
        m = md;
        idx = 0;
        drivePix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 0, 1, 0, 0, m);
        drivePix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 0, 0, 0, 0, m);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < pix; p++) begin
                if (toggleAt >= 0 && idx == toggleAt) m = ~m;
                genPix(kind, idx, y, cb, cr);
                drivePix(y, cb, cr, 0, 0, 1, 1, m);
                idx++;
            end
            drivePix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                     1, 0, 0, 1, m);
            drivePix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                     0, 0, 0, 1, m);
        end
        drivePix(0, 0, 0, 0, 0, 0, 0, m);
        drivePix(0, 0, 0, 0, 0, 0, 0, m);
    endtask

    task automatic checkZero(input string name);
        tests++;
        if (bus.oR !== 8'd0 || bus.oG !== 8'd0 || bus.oB !== 8'd0 ||
            bus.oHSync !== 1'b0 || bus.oVSync !== 1'b0 || bus.oLineValid !== 1'b0 ||
            bus.oFrameValid !== 1'b0 || bus.oModeActive !== 1'b0 || bus.oClampCount !== 16'd0) begin
            fails++;
            $display("FAIL %s got rgb=%0d/%0d/%0d sync=%b%b%b%b mode=%b cc=%0d required all zero",
                     name, bus.oR, bus.oG, bus.oB, bus.oHSync, bus.oVSync, bus.oLineValid,
                     bus.oFrameValid, bus.oModeActive, bus.oClampCount);
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.iLineValid = 1'b0;
        bus.iFrameValid = 1'b0;
        bus.iHSync = 1'b0;
        bus.iVSync = 1'b0;
        #1;
        checkZero("reset_async");
        q.delete();
        mPrevFv = 1'b0; mMode = 1'b0; mAcc = 0; mCc = 0; ccNext = 0; ccPending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkZero("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every output cycle that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                while (q.size() > 0 && q[0].due < cyc) begin
                    e = q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missed_slot due=%0d got cyc=%0d required on time", e.due, cyc);
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    tests++;
                    if (bus.oR !== 8'(e.r) || bus.oG !== 8'(e.g) || bus.oB !== 8'(e.b) ||
                        {bus.oHSync, bus.oVSync, bus.oLineValid, bus.oFrameValid} !== e.tim ||
                        bus.oModeActive !== e.mode || bus.oClampCount !== 16'(e.cc)) begin
                        fails++;
                        $display("FAIL pixel cyc=%0d got rgb=%0d/%0d/%0d sync=%b%b%b%b mode=%b cc=%0d required rgb=%0d/%0d/%0d sync=%b mode=%b cc=%0d",
                                 cyc, bus.oR, bus.oG, bus.oB, bus.oHSync, bus.oVSync,
                                 bus.oLineValid, bus.oFrameValid, bus.oModeActive,
                                 bus.oClampCount, e.r, e.g, e.b, e.tim, e.mode, e.cc);
                    end
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got cyc=%0d required completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int y, cb, cr;
        rst_n = 1'b0;
        bus.iY = '0; bus.iCb = '0; bus.iCr = '0;
        bus.iHSync = 1'b0; bus.iVSync = 1'b0;
        bus.iLineValid = 1'b0; bus.iFrameValid = 1'b0; bus.iMode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkZero("reset_initial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) drivePix(0, 0, 0, 0, 0, 0, 0, 0);

        sendFrame(0, 1'b1, 2, 4, -1);    // gray
        sendFrame(1, 1'b1, 2, 4, -1);    // red
        sendFrame(2, 1'b1, 2, 6, -1);    // saturation corners
        sendFrame(5, 1'b1, 3, 16, -1);   // boundary values, converted
        sendFrame(3, 1'b0, 3, 16, -1);   // random bypass
        sendFrame(3, 1'b0, 3, 8, 10);    // mode flips mid-frame, ignored
        sendFrame(3, 1'b1, 2, 8, -1);    // next frame converts
        sendFrame(4, 1'b1, 1, 70000, -1); // clamp counter saturation

        // Partial frame, then reset while frame valid is high.
        drivePix(0, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            genPix(3, i, y, cb, cr);
            drivePix(y, cb, cr, 0, 0, 1, 1, 1);
        end
        applyReset();
        repeat (2) drivePix(0, 0, 0, 0, 0, 0, 0, 0);
        sendFrame(3, 1'b0, 2, 8, -1);    // bypass after reset

        repeat (5) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
